// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the bus-sharing blocks.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // Only byte/half/word sizes, naturally aligned, go out on the bus.
  function automatic logic req_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping upward.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh_c,
  output logic [IW-1:0] grant_idx_c,
  output logic          grant_valid_c
);

  always_comb begin : search
    logic [IW-1:0] idx;
    idx           = '0;
    grant_oh_c    = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IW'((32'(ptr) + off) % N);
      if (!grant_valid_c && req[idx]) begin
        grant_valid_c   = 1'b1;
        grant_oh_c[idx] = 1'b1;
        grant_idx_c     = idx;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Shares one AHB-Lite slave between NREQ REQ/ACK requesters using a
// round-robin grant and a non-pipelined single-transfer sequencer.
module ahb_req_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned AWIDTH    = 10,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_WR,
  input  logic [NREQ*AWIDTH-1:0] REQ_ADDR,
  input  logic [NREQ*3-1:0]      REQ_SIZE,
  input  logic [NREQ*32-1:0]     REQ_WDATA,
  output logic [NREQ-1:0]        ACK,
  output logic [31:0]            RDATA,
  output logic                   ERR,
  output logic                   HSEL,
  output logic [AWIDTH-1:0]      HADDR,
  output logic                   HWRITE,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic                   HMASTLOCK,
  output logic [3:0]             HPROT,
  output logic [31:0]            HWDATA,
  output logic                   HREADYIN,
  input  logic [31:0]            HRDATA,
  input  logic                   HREADYOUT,
  input  logic                   HRESP
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q;
  logic [NREQ-1:0]   gnt_oh;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_valid;
  logic [NREQ-1:0]   grant_oh_q;
  logic [IW-1:0]     grant_idx_q;
  logic [31:0]       lat_wdata_q;

  logic              sel_wr;
  logic [AWIDTH-1:0] sel_addr;
  logic [2:0]        sel_size;
  logic [31:0]       sel_wdata;

  logic [NREQ-1:0]   ack_d;
  logic [31:0]       rdata_d;
  logic              err_d;
  logic              hsel_d;
  logic [AWIDTH-1:0] haddr_d;
  logic              hwrite_d;
  logic [1:0]        htrans_d;
  logic [2:0]        hsize_d;
  logic [31:0]       hwdata_d;

  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign HREADYIN  = HREADYOUT;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr_arbiter (
    .req           (REQ),
    .ptr           (ptr_q),
    .grant_oh_c    (gnt_oh),
    .grant_idx_c   (gnt_idx),
    .grant_valid_c (gnt_valid)
  );

  // Field mux for the currently winning requester.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_size  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_wr    = REQ_WR[i];
        sel_addr  = REQ_ADDR[i*AWIDTH +: AWIDTH];
        sel_size  = REQ_SIZE[i*3 +: 3];
        sel_wdata = REQ_WDATA[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_valid) state_d = req_legal(sel_size, sel_addr[1:0]) ? ST_ADDR : ST_DONE;
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: if (HREADYOUT) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    ack_d    = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    hsel_d   = 1'b0;
    htrans_d = HTRANS_IDLE;
    haddr_d  = HADDR;
    hwrite_d = HWRITE;
    hsize_d  = HSIZE;
    hwdata_d = HWDATA;
    case (state_d)
      ST_ADDR: begin
        hsel_d   = 1'b1;
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = sel_addr;
        hwrite_d = sel_wr;
        hsize_d  = sel_size;
      end
      ST_DATA: hwdata_d = lat_wdata_q;
      ST_DONE: begin
        if (state_q == ST_IDLE) begin
          ack_d = gnt_oh;
          err_d = 1'b1;
        end else begin
          ack_d   = grant_oh_q;
          err_d   = HRESP;
          rdata_d = HWRITE ? 32'h0 : HRDATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      ACK    <= '0;
      RDATA  <= '0;
      ERR    <= 1'b0;
      HSEL   <= 1'b0;
      HADDR  <= '0;
      HWRITE <= 1'b0;
      HTRANS <= HTRANS_IDLE;
      HSIZE  <= '0;
      HWDATA <= '0;
    end else begin
      ACK    <= ack_d;
      RDATA  <= rdata_d;
      ERR    <= err_d;
      HSEL   <= hsel_d;
      HADDR  <= haddr_d;
      HWRITE <= hwrite_d;
      HTRANS <= htrans_d;
      HSIZE  <= hsize_d;
      HWDATA <= hwdata_d;
    end
  end

  // Grant capture in IDLE; pointer advances past the served requester in DONE.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      ptr_q       <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
      lat_wdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && gnt_valid) begin
        grant_oh_q  <= gnt_oh;
        grant_idx_q <= gnt_idx;
        lat_wdata_q <= sel_wdata;
      end
      if (state_q == ST_DONE) ptr_q <= IW'((32'(grant_idx_q) + 32'd1) % NREQ);
    end
  end

endmodule
